shadow1229_note_sequencer: RTL and testbench
============================================

# shadow1229_note_sequencer

Song sequencer that walks a note ROM and drives the tone generator inside `shadow1229_player`. It fetches 8-bit note entries from an external synchronous ROM and times each note on a tempo tick prescaler. It presents the current note code, a gate, and a note-start strobe to the downstream tone generator, which turns them into `speaker[1:0]`. The song loops forever.

## Interface
- `TICK_COUNT`, 255: clock cycles per duration tick; legal range ≥ 2.
- `ADDR_W`, 10: ROM address width.
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `run` input 1: advance enable; low freezes all state and holds all outputs.
- `rom_addr` output ADDR_W: ROM read address.
- `rom_data` input 8: ROM read data, valid one cycle after `rom_addr`, since the ROM is registered.
- `note` output 5: current note code; 0 means rest.
- `gate` output 1: note sounding.
- `note_start` output 1: one-cycle pulse when a new entry begins; the tone generator resets its phase on this pulse.
- `song_loop` output 1: one-cycle pulse when playback wraps to address 0.

## Operation
- Entry format:
  - `[7:3]` note code. 0 is rest, 1–30 are playable notes, 31 is END.
  - `[2:0]` duration code d, giving 2^d ticks (1–128).
- FSM states: FETCH, LOAD, PLAY, HALT. Reset enters FETCH.
- FETCH: `rom_addr` is stable. Go to LOAD on the next cycle.
- LOAD: decode `rom_data`.
  - END at `rom_addr` ≠ 0: set `rom_addr` to 0, pulse `song_loop`, go to FETCH.
  - END at `rom_addr` = 0 (empty song): go to HALT. `note`=0, `gate`=0.
  - Any other entry:
    - load `note` from the entry, and set `gate` = (note ≠ 0);
    - pulse `note_start`;
    - load the remaining-tick counter with 2^d and clear the prescaler;
    - set `rom_addr` to `rom_addr`+1. When the old address is all-ones, `rom_addr` wraps to 0 and `song_loop` pulses in the same cycle as `note_start`.
    - go to PLAY.
- PLAY:
  - The prescaler counts 0..TICK_COUNT−1. On wrap, the remaining-tick counter decrements.
  - When the counter decrements to 0, go to FETCH.
  - Articulation: if 2^d > 1, `gate` drops to 0 for the whole final tick, i.e. while remaining = 1. `note` holds.
- FETCH and LOAD hold `note` and `gate` from the previous PLAY.
- HALT: terminal until `rst`.
- Duration counter width: 8 bits, which holds 128.
- Prescaler width: enough bits for TICK_COUNT−1.

## Timing
- Reset values, driven in the cycle after `rst` is sampled high:
  - `rom_addr`=0, `note`=0, `gate`=0, `note_start`=0, `song_loop`=0;
  - prescaler=0, counter=0, state FETCH.
- `rst` takes effect from any state, including mid-note. There is no partial output afterwards.
- After `rst` falls, with `run`=1: first `note_start` pulses 2 cycles later (FETCH, then LOAD).
- Entry period, `note_start` to next `note_start`: 2^d·TICK_COUNT + 2 cycles.
- Gate-low final tick: the last TICK_COUNT cycles of PLAY, plus the following FETCH and LOAD cycles.
- END entry costs 2 extra cycles (FETCH, LOAD) before the FETCH of address 0.
- `run`=0 freezes state, prescaler, counter and `rom_addr`.
  - Pulses are not re-emitted or stretched. A pulse due in a frozen cycle is emitted on the first active cycle.
  - The ROM must tolerate a held address; data is re-read validly.
- `run` and `rst` both high: `rst` wins.

## Test plan
- Reset/first note: ROM[0]=0x0A (note 1, d=2), TICK_COUNT=4, pulse `rst` → `note_start` 2 cycles after release; `note`=1, `gate`=1 for 12 cycles, then `gate`=0 for 4+2 cycles; next `note_start` 18 cycles after the first.
- Rest and single tick: ROM = {0x01, 0x48, 0xF8} → rest (`gate`=0) for 8 cycles; then note 9 with d=0 keeps `gate`=1 for its full 4 cycles; then END → `song_loop` pulse; note 0 restarts.
- Empty song: ROM[0]=0xF8 → HALT within 2 cycles; `note`=0, `gate`=0, no pulses for 1000 cycles; `rst` restarts in FETCH.
- Pause: drop `run` for 7 cycles mid-PLAY → `note_start` spacing grows by exactly 7; outputs constant while paused.
- Reset mid-note: assert `rst` during PLAY of entry 3 → next cycle all outputs 0, `rom_addr`=0; playback restarts from entry 0.
- Address wrap: ADDR_W=2, ROM = {0x08, 0x10, 0x18, 0x20} → after entry 3, `rom_addr`=0 and `song_loop` pulses coincident with the `note_start` of note 4.

Source files
------------

// File: rtl/shadow1229_note_sequencer.sv
// Song sequencer for shadow1229_player.
// Walks an external registered note ROM and times each entry with a tempo
// prescaler. It drives note/gate/note_start to the tone generator and loops
// the song forever. An END entry at address 0 (empty song) parks in HALT.
module shadow1229_note_sequencer #(
  parameter int TICK_COUNT = 255,
  parameter int ADDR_W     = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [7:0]        rom_data_i,
  output logic [4:0]        note_o,
  output logic              gate_o,
  output logic              note_start_o,
  output logic              song_loop_o
);

  localparam int                 PRESC_W   = $clog2(TICK_COUNT);
  localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_COUNT - 1);
  localparam logic [4:0]         NOTE_END  = 5'd31;

  typedef enum logic [1:0] {
    FETCH,
    LOAD,
    PLAY,
    HALT
  } state_e;

  state_e             state_q,  state_d;
  logic [ADDR_W-1:0]  addr_q,   addr_d;
  logic [4:0]         note_q,   note_d;
  logic               gate_q,   gate_d;
  logic               start_q,  start_d;
  logic               loop_q,   loop_d;
  logic [PRESC_W-1:0] presc_q,  presc_d;
  logic [7:0]         remain_q, remain_d;

  logic [4:0] entryNote;
  logic [2:0] entryDur;

  assign entryNote = rom_data_i[7:3];
  assign entryDur  = rom_data_i[2:0];

  // Next-state logic: decode entries in LOAD, count ticks in PLAY, hold everything while run is low.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    note_d   = note_q;
    gate_d   = gate_q;
    start_d  = 1'b0;
    loop_d   = 1'b0;
    presc_d  = presc_q;
    remain_d = remain_q;

    if (!run_i) begin
      // A pending pulse waits here and is shown on the first active cycle.
      start_d = start_q;
      loop_d  = loop_q;
    end else begin
      case (state_q)
        FETCH: begin
          state_d = LOAD;
        end

        LOAD: begin
          if (entryNote == NOTE_END) begin
            if (addr_q != '0) begin
              addr_d  = '0;
              loop_d  = 1'b1;
              state_d = FETCH;
            end else begin
              note_d  = 5'd0;
              gate_d  = 1'b0;
              state_d = HALT;
            end
          end else begin
            note_d   = entryNote;
            gate_d   = (entryNote != 5'd0);
            start_d  = 1'b1;
            remain_d = 8'd1 << entryDur;
            presc_d  = '0;
            addr_d   = addr_q + ADDR_W'(1);
            loop_d   = &addr_q;
            state_d  = PLAY;
          end
        end

        PLAY: begin
          if (presc_q == TICK_LAST) begin
            presc_d  = '0;
            remain_d = remain_q - 8'd1;
            // Entering the final tick of a multi-tick note: release the gate.
            if (remain_q == 8'd2) begin
              gate_d = 1'b0;
            end
            if (remain_q == 8'd1) begin
              state_d = FETCH;
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end

        HALT: begin
          state_d = HALT;
        end

        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // State register with synchronous reset that wins over run.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= FETCH;
      addr_q   <= '0;
      note_q   <= 5'd0;
      gate_q   <= 1'b0;
      start_q  <= 1'b0;
      loop_q   <= 1'b0;
      presc_q  <= '0;
      remain_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      note_q   <= note_d;
      gate_q   <= gate_d;
      start_q  <= start_d;
      loop_q   <= loop_d;
      presc_q  <= presc_d;
      remain_q <= remain_d;
    end
  end

  assign rom_addr_o   = addr_q;
  assign note_o       = note_q;
  assign gate_o       = gate_q;
  assign note_start_o = start_q & run_i;
  assign song_loop_o  = loop_q & run_i;

endmodule

// File: tb/tb_shadow1229_note_sequencer.sv
// Directed bench for shadow1229_note_sequencer with TICK_COUNT=4.
// A main instance (ADDR_W=4) covers playback, rests, END looping, the empty
// song, pause and mid-note reset. A second instance (ADDR_W=2) covers
// address wrap.
module tb_shadow1229_note_sequencer;

  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b1;

  logic [3:0] romAddr;
  logic [7:0] romData;
  logic [4:0] note;
  logic       gate;
  logic       noteStart;
  logic       songLoop;

  logic [1:0] romAddrW;
  logic [7:0] romDataW;
  logic [4:0] noteW;
  logic       gateW;
  logic       noteStartW;
  logic       songLoopW;

  logic [7:0] romMain [0:15];
  logic [7:0] romW    [0:3];

  int checkCount = 0;
  int passCount  = 0;
  int steps;
  int activity;
  int extraStarts;

  shadow1229_note_sequencer #(.TICK_COUNT(TICK), .ADDR_W(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .run_i        (run),
    .rom_addr_o   (romAddr),
    .rom_data_i   (romData),
    .note_o       (note),
    .gate_o       (gate),
    .note_start_o (noteStart),
    .song_loop_o  (songLoop)
  );

  shadow1229_note_sequencer #(.TICK_COUNT(TICK), .ADDR_W(2)) dutW (
    .clk_i        (clk),
    .rst_i        (rst),
    .run_i        (run),
    .rom_addr_o   (romAddrW),
    .rom_data_i   (romDataW),
    .note_o       (noteW),
    .gate_o       (gateW),
    .note_start_o (noteStartW),
    .song_loop_o  (songLoopW)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Registered ROMs: data appears one cycle after the address.
  always @(posedge clk) begin
    romData  <= romMain[romAddr];
    romDataW <= romW[romAddrW];
  end

  // Count one comparison and report it when it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive rst/run, then advance the given number of cycles; samples land 1 time unit after the edge.
  task automatic applyStimulus(input logic rstVal, input logic runVal, input int cycles);
    rst = rstVal;
    run = runVal;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Step until a note_start is seen on the chosen instance; steps is -1 if the budget runs out.
  task automatic waitStart(input bit useW, input int budget, output int stepsOut);
    stepsOut = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if ((useW ? noteStartW : noteStart) === 1'b1) begin
        stepsOut = i;
        break;
      end
    end
  endtask

  // Fill the main ROM with END entries.
  task automatic clearMain();
    for (int i = 0; i < 16; i++) begin
      romMain[i] = 8'hF8;
    end
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearMain();
    romW[0] = 8'h08;
    romW[1] = 8'h10;
    romW[2] = 8'h18;
    romW[3] = 8'h20;

    // ---- Reset / first note, articulation, then pause ----
    romMain[0] = 8'h0A;
    romMain[1] = 8'h0A;
    romMain[2] = 8'h0A;
    applyStimulus(1'b1, 1'b1, 2);
    checkOutput("resetAddr",  romAddr,   0);
    checkOutput("resetNote",  note,      0);
    checkOutput("resetGate",  gate,      0);
    checkOutput("resetStart", noteStart, 0);
    checkOutput("resetLoop",  songLoop,  0);

    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("loadNoStart", noteStart, 0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("firstStart", noteStart, 1);
    checkOutput("firstNote",  note,      1);
    checkOutput("firstGate",  gate,      1);
    checkOutput("firstAddr",  romAddr,   1);

    extraStarts = 0;
    for (int i = 1; i < 18; i++) begin
      applyStimulus(1'b0, 1'b1, 1);
      checkOutput("gateShape", gate, (i < 12) ? 1 : 0);
      if (noteStart === 1'b1) extraStarts++;
    end
    checkOutput("noEarlyStart", extraStarts, 0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("periodStart", noteStart, 1);
    checkOutput("periodAddr",  romAddr,   2);

    applyStimulus(1'b0, 1'b1, 5);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("pauseHold", {note, gate, romAddr, noteStart}, {5'd1, 1'b1, 4'd2, 1'b0});
    end
    run = 1'b1;
    waitStart(1'b0, 40, steps);
    checkOutput("pauseSpacing", 5 + 7 + steps, 25);

    // ---- Rest, single tick, END loop ----
    clearMain();
    romMain[0] = 8'h01;
    romMain[1] = 8'h48;
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 2);
    checkOutput("restStart", noteStart, 1);
    checkOutput("restNote",  note,      0);
    activity = 0;
    for (int i = 1; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1);
      if (gate !== 1'b0) activity++;
    end
    checkOutput("restGateLow", activity, 0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("tickStart", noteStart, 1);
    checkOutput("tickNote",  note,      9);
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("tickGateEnd", gate, 1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("tickGateFetch", gate, 1);
    applyStimulus(1'b0, 1'b1, 2);
    checkOutput("endLoop",    songLoop,  1);
    checkOutput("endAddr",    romAddr,   0);
    checkOutput("endNoStart", noteStart, 0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("endLoopOnce", songLoop, 0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("restartStart", noteStart, 1);
    checkOutput("restartNote",  note,      0);
    checkOutput("restartLoop",  songLoop,  0);

    // ---- Empty song halts ----
    clearMain();
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 2);
    checkOutput("haltOutputs", {note, gate, romAddr, noteStart, songLoop}, 0);
    activity = 0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b0, 1'b1, 1);
      if (noteStart !== 1'b0 || songLoop !== 1'b0 || gate !== 1'b0 ||
          note !== 5'd0 || romAddr !== 4'd0) activity++;
    end
    checkOutput("haltQuiet", activity, 0);
    romMain[0] = 8'h0A;
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("haltResetLoad", noteStart, 0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("haltResetStart", noteStart, 1);
    checkOutput("haltResetNote",  note,      1);

    // ---- Reset mid-note during entry 3 ----
    clearMain();
    romMain[0] = 8'h0A;
    romMain[1] = 8'h11;
    romMain[2] = 8'h1A;
    romMain[3] = 8'h21;
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 2);
    checkOutput("midStart0", noteStart, 1);
    waitStart(1'b0, 40, steps);
    checkOutput("midSpacing1", steps, 18);
    checkOutput("midNote1",    note,  2);
    waitStart(1'b0, 40, steps);
    checkOutput("midSpacing2", steps, 10);
    checkOutput("midNote2",    note,  3);
    waitStart(1'b0, 40, steps);
    checkOutput("midSpacing3", steps, 18);
    checkOutput("midNote3",    note,  4);
    checkOutput("midAddr3",    romAddr, 4);
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("midReset", {note, gate, romAddr, noteStart, songLoop}, 0);
    applyStimulus(1'b0, 1'b1, 2);
    checkOutput("midRestartStart", noteStart, 1);
    checkOutput("midRestartNote",  note,      1);
    checkOutput("midRestartAddr",  romAddr,   1);

    // ---- Address wrap on the narrow instance ----
    applyStimulus(1'b1, 1'b1, 2);
    rst = 1'b0;
    waitStart(1'b1, 10, steps);
    checkOutput("wrapFirst", steps, 2);
    checkOutput("wrapNote1", noteW, 1);
    checkOutput("wrapLoop1", songLoopW, 0);
    for (int k = 2; k <= 3; k++) begin
      waitStart(1'b1, 20, steps);
      checkOutput("wrapSpacing", steps, 6);
      checkOutput("wrapNote",    noteW, k);
      checkOutput("wrapNoLoop",  songLoopW, 0);
    end
    waitStart(1'b1, 20, steps);
    checkOutput("wrapSpacing4", steps,     6);
    checkOutput("wrapNote4",    noteW,     4);
    checkOutput("wrapLoop4",    songLoopW, 1);
    checkOutput("wrapAddr4",    romAddrW,  0);
    waitStart(1'b1, 20, steps);
    checkOutput("wrapSpacing5", steps,     6);
    checkOutput("wrapNote5",    noteW,     1);
    checkOutput("wrapLoop5",    songLoopW, 0);
    checkOutput("wrapAddr5",    romAddrW,  1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
